// File: rtl/stream_demux_n.sv
// stream_demux_n: registered 1:NUM_CH valid/ready demux with broadcast and out-of-range drop counting
module stream_demux_n #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W = $clog2(NUM_CH),
  parameter int ERR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_bcast,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic                     err_pulse,
  output logic [ERR_W-1:0]         err_cnt
);
  localparam logic [SEL_W:0] CH_LIM = (SEL_W+1)'(NUM_CH);
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [DATA_W-1:0] data_q;
  logic accept, drop;
  assign in_ready = ~|(pend_q & ~out_ready);
  assign accept = in_valid & in_ready;
  assign drop = accept & ~in_bcast & ({1'b0, in_sel} >= CH_LIM);
  assign out_valid = pend_q;
  assign out_data = {NUM_CH{data_q}};
  always_comb begin
    pend_d = accept ? (in_bcast ? '1 : drop ? '0 : NUM_CH'(1) << in_sel) : pend_q & ~out_ready;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      data_q <= '0;
      err_pulse <= 1'b0;
      err_cnt <= '0;
    end else begin
      pend_q <= pend_d;
      if (accept && !drop) data_q <= in_data;
      err_pulse <= drop;
      err_cnt <= err_cnt + ERR_W'(drop && !(&err_cnt));
    end
  end
endmodule

// File: tb/tb_stream_demux_n.sv
// tb_stream_demux_n: table-driven directed checks of stream_demux_n plus multi-cycle corner sequences
module tb_stream_demux_n;
  typedef struct {
    logic v;
    logic [1:0] sel;
    logic b;
    logic [7:0] d;
    logic [3:0] rdy;
    logic exp_rdy;
    logic [3:0] exp_ov;
    logic [7:0] exp_d;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid, in_ready, in_bcast, err_pulse;
  logic [7:0] in_data, err_cnt;
  logic [1:0] in_sel;
  logic [3:0] out_valid, out_ready;
  logic [31:0] out_data;
  logic t_valid, t_ready, t_bcast, t_pulse;
  logic [7:0] t_data, t_cnt;
  logic [1:0] t_sel;
  logic [2:0] t_ovalid, t_oready;
  logic [23:0] t_odata;
  int vectors = 0;
  int miscompares = 0;
  vec_t tbl[$];
  always #5 clk = ~clk;
  stream_demux_n #(.DATA_W(8), .NUM_CH(4), .ERR_W(8)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_bcast(in_bcast), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .err_pulse(err_pulse), .err_cnt(err_cnt)
  );
  stream_demux_n #(.DATA_W(8), .NUM_CH(3), .ERR_W(8)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(t_valid), .in_ready(t_ready), .in_data(t_data),
    .in_sel(t_sel), .in_bcast(t_bcast), .out_valid(t_ovalid), .out_ready(t_oready),
    .out_data(t_odata), .err_pulse(t_pulse), .err_cnt(t_cnt)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic add(input logic v, input logic [1:0] sel, input logic b, input logic [7:0] d,
                     input logic [3:0] rdy, input logic er, input logic [3:0] eov, input logic [7:0] ed);
    tbl.push_back('{v, sel, b, d, rdy, er, eov, ed});
  endtask
  task automatic step(input vec_t x, input int i);
    @(negedge clk);
    in_valid = x.v; in_sel = x.sel; in_bcast = x.b; in_data = x.d; out_ready = x.rdy;
    #1 chk($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(x.exp_rdy));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(x.exp_ov));
    chk($sformatf("v%0d out_data", i), 64'(out_data), 64'({4{x.exp_d}}));
  endtask
  initial begin
    in_valid = 0; in_sel = 0; in_bcast = 0; in_data = 0; out_ready = 4'hF;
    t_valid = 0; t_sel = 0; t_bcast = 0; t_data = 0; t_oready = 3'h7;
    #1 rst_n = 1'b0;
    #1;
    chk("rst out_valid", 64'(out_valid), 0);
    chk("rst out_data", 64'(out_data), 0);
    chk("rst in_ready", 64'(in_ready), 1);
    chk("rst err_pulse", 64'(err_pulse), 0);
    chk("rst err_cnt", 64'(err_cnt), 0);
    @(negedge clk) rst_n = 1'b1;
    add(1, 2, 0, 8'hA5, 4'hF, 1, 4'b0100, 8'hA5);
    add(0, 0, 0, 8'h00, 4'hF, 1, 4'b0000, 8'hA5);
    add(1, 0, 0, 8'h11, 4'hF, 1, 4'b0001, 8'h11);
    add(1, 1, 0, 8'h22, 4'hF, 1, 4'b0010, 8'h22);
    add(1, 2, 0, 8'h33, 4'hF, 1, 4'b0100, 8'h33);
    add(1, 3, 0, 8'h44, 4'hF, 1, 4'b1000, 8'h44);
    add(0, 0, 0, 8'h00, 4'hF, 1, 4'b0000, 8'h44);
    add(1, 0, 1, 8'h3C, 4'hF, 1, 4'b1111, 8'h3C);
    add(1, 0, 0, 8'h99, 4'b0101, 0, 4'b1010, 8'h3C);
    add(0, 0, 0, 8'h99, 4'b1010, 1, 4'b0000, 8'h3C);
    add(1, 1, 0, 8'h5A, 4'hF, 1, 4'b0010, 8'h5A);
    for (int k = 0; k < 5; k++) add(1, 2, 0, 8'h77, 4'b1101, 0, 4'b0010, 8'h5A);
    add(1, 2, 0, 8'h77, 4'hF, 1, 4'b0100, 8'h77);
    add(0, 0, 0, 8'h00, 4'hF, 1, 4'b0000, 8'h77);
    add(1, 3, 0, 8'h01, 4'hF, 1, 4'b1000, 8'h01);
    add(1, 0, 1, 8'hE1, 4'hF, 1, 4'b1111, 8'hE1);
    add(0, 0, 0, 8'h00, 4'hF, 1, 4'b0000, 8'hE1);
    add(1, 0, 1, 8'hB4, 4'h0, 1, 4'b1111, 8'hB4);
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);
    chk("pow2 err_cnt", 64'(err_cnt), 0);
    @(negedge clk);
    in_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 64'(out_valid), 0);
    chk("midrst in_ready", 64'(in_ready), 1);
    chk("midrst out_data", 64'(out_data), 0);
    chk("midrst err_cnt", 64'(err_cnt), 0);
    #1 rst_n = 1'b1;
    step('{1, 0, 0, 8'hD2, 4'hF, 1, 4'b0001, 8'hD2}, 100);
    @(negedge clk);
    t_valid = 1; t_sel = 3; t_data = 8'hEE;
    @(posedge clk);
    #1;
    chk("oor err_pulse", 64'(t_pulse), 1);
    chk("oor err_cnt", 64'(t_cnt), 1);
    chk("oor out_valid", 64'(t_ovalid), 0);
    chk("oor out_data", 64'(t_odata), 0);
    @(negedge clk);
    t_valid = 0;
    @(posedge clk);
    #1 chk("oor pulse clear", 64'(t_pulse), 0);
    @(negedge clk);
    t_valid = 1; t_sel = 1; t_data = 8'hC3;
    @(posedge clk);
    #1 chk("ch3 route valid", 64'(t_ovalid), 3'b010);
    @(negedge clk);
    t_sel = 3; t_data = 8'h55;
    for (int k = 0; k < 300; k++) @(posedge clk);
    #1 chk("oor run pulse", 64'(t_pulse), 1);
    @(negedge clk);
    t_valid = 0;
    @(posedge clk);
    #1;
    chk("sat err_cnt", 64'(t_cnt), 255);
    chk("sat err_pulse", 64'(t_pulse), 0);
    chk("sat out_valid", 64'(t_ovalid), 0);
    chk("drop keeps data", 64'(t_odata), 64'({3{8'hC3}}));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
